hub75_capture: RTL and testbench

- Receive-side counterpart of the LED matrix driver: a panel model and loopback monitor for the 32x32 HUB75-style scan stream.
- Samples the serial panel interface (sclk, R0/G0/B0/R1/G1/B1, A, lch, blank) with the system clock and rebuilds the displayed frame in an internal pixel store.
- Exposes that frame through a registered read port, plus row/frame status and protocol-error flags.
- Used for on-chip self-check of the driver and as the bench model of the panel.

---
 rtl/hub75_capture.sv | 156 +++++++++++++++
 tb/tb_hub75_capture.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 panel model / loopback monitor: samples the serial scan stream and
// rebuilds the displayed frame in a pixel store with a registered read port.
module hub75_capture #(
   parameter int COLS        = 32,
   parameter int ROWS        = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sclk,
   input  logic                      r0,
   input  logic                      g0,
   input  logic                      b0,
   input  logic                      r1,
   input  logic                      g1,
   input  logic                      b1,
   input  logic [$clog2(ROWS/2)-1:0] a,
   input  logic                      lch,
   input  logic                      blank,
   input  logic [$clog2(ROWS)-1:0]   rd_row,
   input  logic [$clog2(COLS)-1:0]   rd_col,
   output logic [2:0]                rd_rgb,
   output logic                      row_commit,
   output logic [$clog2(ROWS/2)-1:0] commit_row,
   output logic                      frame_done,
   output logic                      err_count,
   output logic                      err_blank,
   input  logic                      err_clr
);

   localparam int AW = $clog2(ROWS/2);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int BW = $clog2(COLS+1);
   localparam logic [BW-1:0] COLS_B = BW'(COLS);
   localparam logic [BW-1:0] LAST_B = BW'(COLS-1);

   typedef struct packed {
      logic          blank;
      logic          lch;
      logic [AW-1:0] a;
      logic [2:0]    hi;
      logic [2:0]    lo;
      logic          sclk;
   } pins_t;

   typedef enum logic [1:0] {S_SHIFT, S_FULL, S_COMMIT} state_t;

   pins_t         pins_in, pins_s, pins_d;
   pins_t         sync_q [SYNC_STAGES];
   state_t        state, state_n;
   logic [BW-1:0] bit_cnt;
   logic [AW-1:0] latch_a, last_row;
   logic          first_commit;
   logic          shift_en, lch_rise;
   logic          err_count_set, err_blank_set;
   logic [RW-1:0] upper_row, lower_row;
   logic [2:0]    upper_buf [COLS];
   logic [2:0]    lower_buf [COLS];
   logic [2:0]    store     [ROWS][COLS];

   assign pins_in = {blank, lch, a, r0, g0, b0, r1, g1, b1, sclk};

   // Data and address are taken from the same stage as the edge so they stay aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         pins_d <= '0;
      end else begin
         sync_q[0] <= pins_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         pins_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign pins_s    = sync_q[SYNC_STAGES-1];
   assign shift_en  = pins_s.sclk & ~pins_d.sclk & ~pins_s.lch;
   assign lch_rise  = pins_s.lch & ~pins_d.lch;
   assign upper_row = RW'(latch_a);
   assign lower_row = upper_row + RW'(ROWS/2);

   assign err_count_set = (shift_en && bit_cnt == COLS_B) || (lch_rise && bit_cnt != COLS_B);
   assign err_blank_set = lch_rise && !pins_s.blank;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_SHIFT;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_SHIFT:  if (lch_rise) state_n = S_COMMIT;
                   else if (shift_en && bit_cnt == LAST_B) state_n = S_FULL;
         S_FULL:   if (lch_rise) state_n = S_COMMIT;
         S_COMMIT: state_n = S_SHIFT;
         default:  state_n = S_SHIFT;
      endcase
   end

   always_comb begin
      row_commit = (state == S_COMMIT);
      frame_done = row_commit && !first_commit && (latch_a <= last_row);
   end

   assign commit_row = latch_a;

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt      <= '0;
         latch_a      <= '0;
         last_row     <= '0;
         first_commit <= 1'b1;
         err_count    <= 1'b0;
         err_blank    <= 1'b0;
         for (int c = 0; c < COLS; c++) begin
            upper_buf[c] <= '0;
            lower_buf[c] <= '0;
         end
      end else begin
         if (shift_en && bit_cnt < COLS_B) begin
            upper_buf[bit_cnt[CW-1:0]] <= pins_s.hi;
            lower_buf[bit_cnt[CW-1:0]] <= pins_s.lo;
            bit_cnt                    <= bit_cnt + 1'b1;
         end
         if (lch_rise) latch_a <= pins_s.a;
         if (state == S_COMMIT) begin
            bit_cnt      <= '0;
            last_row     <= latch_a;
            first_commit <= 1'b0;
         end
         // A same-cycle set wins over the clear.
         err_count <= err_count_set | (err_count & ~err_clr);
         err_blank <= err_blank_set | (err_blank & ~err_clr);
      end
   end

   // NOTE: the pixel store is deliberately reset, so it is built from flops, not RAM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_rgb <= '0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) store[r][c] <= '0;
      end else begin
         rd_rgb <= store[rd_row][rd_col];
         if (state == S_COMMIT) begin
            for (int c = 0; c < COLS; c++) begin
               store[upper_row][c] <= upper_buf[c];
               store[lower_row][c] <= lower_buf[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_hub75_capture.sv
// Self-checking bench for hub75_capture: directed row scenarios with random
// pixel data, checked against a frame-level reference model.
module tb_hub75_capture;

   logic       clk = 1'b0;
   logic       reset, sclk, r0, g0, b0, r1, g1, b1, lch, blank, err_clr;
   logic [3:0] a;
   logic [4:0] rd_row, rd_col;
   logic [2:0] rd_rgb;
   logic       row_commit, frame_done, err_count, err_blank;
   logic [3:0] commit_row;

   hub75_capture #(.COLS(32), .ROWS(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .sclk(sclk),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .a(a), .lch(lch), .blank(blank),
      .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
      .row_commit(row_commit), .commit_row(commit_row), .frame_done(frame_done),
      .err_count(err_count), .err_blank(err_blank), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observed pulse activity.
   int         n_commits = 0;
   int         n_frames  = 0;
   logic [3:0] last_commit_row = '0;

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (row_commit === 1'b1) begin
            n_commits++;
            last_commit_row = commit_row;
         end
         if (frame_done === 1'b1) n_frames++;
      end
   end

   // Reference model of the panel.
   logic [2:0] m_store [32][32];
   logic [2:0] m_up [32];
   logic [2:0] m_lo [32];
   int         m_last;
   bit         m_first;
   int         exp_commits = 0;
   int         exp_frames  = 0;
   bit         exp_ec, exp_eb;
   logic [2:0] up_pat [40];
   logic [2:0] lo_pat [40];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++) m_store[r][c] = '0;
      for (int c = 0; c < 32; c++) begin
         m_up[c] = '0;
         m_lo[c] = '0;
      end
      m_last  = 0;
      m_first = 1'b1;
      exp_ec  = 1'b0;
      exp_eb  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      sclk = 1'b0; lch = 1'b0; blank = 1'b1; err_clr = 1'b0;
      {r0, g0, b0, r1, g1, b1} = '0;
      a = '0;
      model_reset();
      wait_clk(3);
      reset = 1'b1;
      wait_clk(2);
   endtask

   task automatic fill_random();
      for (int k = 0; k < 40; k++) begin
         up_pat[k] = 3'($urandom_range(7, 0));
         lo_pat[k] = 3'($urandom_range(7, 0));
      end
   endtask

   task automatic shift_bit(input int k);
      @(negedge clk);
      {r0, g0, b0} = up_pat[k];
      {r1, g1, b1} = lo_pat[k];
      sclk = 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      if (k < 32) begin
         m_up[k] = up_pat[k];
         m_lo[k] = lo_pat[k];
      end else begin
         exp_ec = 1'b1;
      end
   endtask

   task automatic send_row(input logic [3:0] av, input int nbits, input logic bl);
      a     = av;
      blank = bl;
      for (int k = 0; k < nbits; k++) shift_bit(k);
      lch = 1'b1;
      wait_clk(8);
      lch = 1'b0;
      wait_clk(4);
      if (nbits != 32) exp_ec = 1'b1;
      if (!bl) exp_eb = 1'b1;
      for (int c = 0; c < 32; c++) begin
         m_store[av][c]      = m_up[c];
         m_store[av + 16][c] = m_lo[c];
      end
      if (!m_first && int'(av) <= m_last) exp_frames++;
      m_last  = int'(av);
      m_first = 1'b0;
      exp_commits++;
      check($sformatf("commits_a%0d", av), n_commits, exp_commits);
      check($sformatf("commit_row_a%0d", av), last_commit_row, av);
      check($sformatf("frames_a%0d", av), n_frames, exp_frames);
      check($sformatf("err_count_a%0d", av), err_count, exp_ec);
      check($sformatf("err_blank_a%0d", av), err_blank, exp_eb);
   endtask

   task automatic check_row(input int r);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         rd_row = 5'(r);
         rd_col = 5'(c);
         @(negedge clk);
         check($sformatf("pix_r%0d_c%0d", r, c), rd_rgb, m_store[r][c]);
      end
   endtask

   task automatic check_all();
      for (int r = 0; r < 32; r++) check_row(r);
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ec = 1'b0;
      exp_eb = 1'b0;
      wait_clk(1);
      check("err_count_clr", err_count, exp_ec);
      check("err_blank_clr", err_blank, exp_eb);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int f_base;
      int c_base;
      rd_row = '0;
      rd_col = '0;
      do_reset();

      // Reset state.
      check("rst_row_commit", row_commit, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_commit_row", commit_row, 4'd0);
      check("rst_err_count", err_count, 1'b0);
      check("rst_err_blank", err_blank, 1'b0);
      check_all();

      // Solid colours on row pair 3.
      for (int k = 0; k < 40; k++) begin
         up_pat[k] = 3'b100;
         lo_pat[k] = 3'b001;
      end
      send_row(4'd3, 32, 1'b1);
      check_row(3);
      check_row(19);

      // Column ordering: bit k drives r0 = k[0].
      fill_random();
      for (int k = 0; k < 32; k++) up_pat[k] = {k[0], 2'b00};
      send_row(4'd5, 32, 1'b1);
      check_row(5);
      check_row(21);

      // Short row: sticky count error, old buffer contents remain in columns 30..31.
      fill_random();
      send_row(4'd7, 30, 1'b1);
      check_row(7);
      check_row(23);
      fill_random();
      send_row(4'd10, 32, 1'b1);
      pulse_err_clr();

      // Overflow: the 33rd bit is dropped.
      fill_random();
      up_pat[32] = ~up_pat[31];
      lo_pat[32] = ~lo_pat[31];
      send_row(4'd8, 33, 1'b1);
      check_row(8);
      check_row(24);
      pulse_err_clr();

      // Latch while blank low still commits.
      fill_random();
      send_row(4'd9, 32, 1'b0);
      check_row(9);
      check_row(25);
      pulse_err_clr();

      // Full frame, then wrap on row 0.
      do_reset();
      f_base = n_frames;
      for (int r = 0; r < 16; r++) begin
         fill_random();
         send_row(4'(r), 32, 1'b1);
      end
      check("no_frame_before_wrap", n_frames - f_base, 0);
      fill_random();
      send_row(4'd0, 32, 1'b1);
      check("frame_once", n_frames - f_base, 1);
      check_row(0);
      check_row(16);
      check_row(12);

      // Reset in the middle of a row: partial row discarded, store cleared.
      fill_random();
      a = 4'd2;
      for (int k = 0; k < 10; k++) shift_bit(k);
      c_base = n_commits;
      do_reset();
      wait_clk(10);
      check("mid_reset_no_commit", n_commits, c_base);
      check("mid_reset_err_count", err_count, 1'b0);
      check("mid_reset_commit_row", commit_row, 4'd0);
      check_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
